// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues read bursts from the fetch PC, buffers the
// returned words with their addresses and hands them to decode one at a time.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(32'h80020000),
    parameter int                    BUF_DEPTH  = 16,
    parameter logic [1:0]            BURST_SIZE = 2'b01
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    output logic                  mem_enable,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] insn,
    output logic [ADDR_WIDTH-1:0] insn_pc,
    output logic                  insn_valid,
    input  logic                  insn_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam int BURST_LEN = (BURST_SIZE == 2'b00) ? 1 :
                               (BURST_SIZE == 2'b01) ? 4 :
                               (BURST_SIZE == 2'b10) ? 8 : 16;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0]            LAST_WORD   = 4'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]      MAX_FILL    = CNT_W'(BUF_DEPTH - BURST_LEN);
    localparam logic [CNT_W-1:0]      FULL        = CNT_W'(BUF_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(4 * BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RECV,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] insn;
    } entry_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic                  mem_enable_q, mem_enable_d;
    logic [3:0]            word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    entry_t                head_q, head_d;
    entry_t                buf_mem [BUF_DEPTH];

    logic   push_en;
    logic   pop_en;
    logic   accepted;
    logic   last_word;
    logic   space_ok;
    entry_t push_entry;

    assign accepted  = mem_enable_q && !mem_busy;
    assign last_word = (word_cnt_q == LAST_WORD);
    assign push_en   = (state_q == RECV) && !redirect;
    assign pop_en    = (count_q != '0) && insn_ready && !redirect;
    // Space is judged on the post-edge occupancy so a request is only raised
    // when a whole burst is guaranteed to fit.
    assign space_ok  = (count_d <= MAX_FILL);

    always_comb begin
        push_entry.pc   = mem_address_q + ADDR_WIDTH'({word_cnt_q, 2'b00});
        push_entry.insn = mem_data;
    end

    // Buffer bookkeeping; head_q mirrors the oldest entry as a registered output.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
        head_d   = head_q;
        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (push_en && (count_q == '0 || (count_q == CNT_W'(1) && pop_en))) begin
            head_d = push_entry;
        end else if (pop_en && count_q > CNT_W'(1)) begin
            head_d = buf_mem[rd_ptr_q + PTR_W'(1)];
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        mem_address_d = mem_address_q;
        mem_enable_d  = mem_enable_q;
        word_cnt_d    = word_cnt_q;

        if (redirect) begin
            fetch_pc_d   = redirect_pc & ALIGN_MASK;
            mem_enable_d = 1'b0;
            case (state_q)
                REQ: begin
                    if (accepted) begin
                        word_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RECV, DRAIN: begin
                    if (last_word) begin
                        state_d = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 4'd1;
                        state_d    = DRAIN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (space_ok) begin
                        mem_enable_d  = 1'b1;
                        mem_address_d = fetch_pc_q;
                        state_d       = REQ;
                    end
                end
                REQ: begin
                    if (accepted) begin
                        mem_enable_d = 1'b0;
                        fetch_pc_d   = fetch_pc_q + BURST_BYTES;
                        word_cnt_d   = '0;
                        state_d      = RECV;
                    end
                end
                RECV: begin
                    if (!last_word) begin
                        word_cnt_d = word_cnt_q + 4'd1;
                    end else if (space_ok) begin
                        mem_enable_d  = 1'b1;
                        mem_address_d = fetch_pc_q;
                        state_d       = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (last_word) begin
                        state_d = IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
        if (reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= START_ADDR;
            mem_address_q <= START_ADDR;
            mem_enable_q  <= 1'b0;
            word_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            head_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_address_q <= mem_address_d;
            mem_enable_q  <= mem_enable_d;
            word_cnt_q    <= word_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            head_q        <= head_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after count says it was written.
    always_ff @(posedge clock) begin
        if (push_en) begin
            buf_mem[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_en && !pop_en) begin
            assert (count_q != FULL);
        end
    end

    assign mem_address     = mem_address_q;
    assign mem_enable      = mem_enable_q;
    assign mem_access_size = BURST_SIZE;
    assign mem_rw          = 1'b0;
    assign insn            = head_q.insn;
    assign insn_pc         = head_q.pc;
    assign insn_valid      = (count_q != '0);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a memory responder and
// an in-order instruction scoreboard kept in the bench.
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h80020000;
    localparam int          N     = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic        mem_busy;
    logic [31:0] mem_data;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_valid;
    logic        insn_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .START_ADDR(32'h80020000),
        .BUF_DEPTH (16),
        .BURST_SIZE(2'b01)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_access_size(mem_access_size),
        .mem_rw         (mem_rw),
        .mem_enable     (mem_enable),
        .mem_busy       (mem_busy),
        .mem_data       (mem_data),
        .insn           (insn),
        .insn_pc        (insn_pc),
        .insn_valid     (insn_valid),
        .insn_ready     (insn_ready),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Memory responder state
    int          busy_left  = 0;
    int          word_k     = 0;
    int          stall_left = 0;
    logic [31:0] burst_base = '0;
    bit          use_seq    = 1'b0;
    logic [31:0] salt       = '0;
    logic [31:0] sent [logic [31:0]];

    // Reference model: delivered-but-unconsumed words, next PC decode should
    // see, next address the fetcher should request.
    int          occ      = 0;
    bit          drained  = 1'b0;
    logic [31:0] exp_pc   = START;
    logic [31:0] exp_req  = START;
    int          accepts  = 0;
    int          pops     = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return (addr * 32'h9E3779B1) ^ salt;
    endfunction

    task automatic drive_mem();
        logic [31:0] a;
        logic [31:0] d;
        mem_busy = (busy_left > 0) || (stall_left > 0);
        if (busy_left > 0) begin
            a = burst_base + 32'(4 * word_k);
            d = use_seq ? (32'hA0 + 32'(word_k)) : word_at(a);
            sent[a] = d;
            mem_data = d;
        end else begin
            mem_data = $urandom;
        end
    endtask

    // One clock: score what crosses the edge, advance models, re-drive memory.
    task automatic cycle();
        logic        acc;
        logic        pop_ok;
        logic        word_in;
        logic        redir;
        logic        rst;
        logic        req_pending;
        logic [31:0] addr_s;
        logic [31:0] exp_d;
        rst         = (reset === 1'b1);
        redir       = (redirect === 1'b1);
        acc         = (mem_enable === 1'b1) && (mem_busy === 1'b0) && !rst;
        req_pending = (mem_enable === 1'b1) && !acc && !redir && !rst;
        pop_ok      = (insn_valid === 1'b1) && (insn_ready === 1'b1) && !redir && !rst;
        word_in     = (busy_left > 0);
        addr_s      = mem_address;

        if (pop_ok) begin
            exp_d = sent.exists(exp_pc) ? sent[exp_pc] : 'x;
            check("pop_pc", insn_pc, exp_pc);
            check("pop_insn", insn, exp_d);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (acc) begin
            check("req_addr", addr_s, exp_req);
        end

        @(posedge clock);
        #1;

        if (rst) begin
            busy_left  = 0;
            stall_left = 0;
            occ        = 0;
            drained    = 1'b0;
            exp_pc     = START;
            exp_req    = START;
        end else begin
            if (word_in) begin
                if (!drained && !redir) occ++;
                busy_left--;
                word_k++;
            end
            if (pop_ok) occ--;
            if (redir) begin
                occ     = 0;
                drained = 1'b1;
                exp_pc  = redirect_pc & ~32'd3;
                exp_req = redirect_pc & ~32'd3;
            end
            if (acc) begin
                burst_base = addr_s;
                busy_left  = N;
                word_k     = 0;
                drained    = redir;
                if (!redir) exp_req = exp_req + 32'(4 * N);
                accepts++;
            end
            if (stall_left > 0) stall_left--;
        end
        drive_mem();

        check("insn_valid", insn_valid, occ != 0);
        check("occ_bound", occ <= 16, 1);
        if (req_pending) begin
            check("req_hold_enable", mem_enable, 1);
            check("req_hold_addr", mem_address, addr_s);
        end
    endtask

    task automatic wait_for_enable(input int limit, input string tag);
        int n = 0;
        while (mem_enable !== 1'b1 && n < limit) begin
            cycle();
            n++;
        end
        check(tag, mem_enable, 1);
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        redirect   = 1'b0;
        stall_left = 0;
        drive_mem();
        repeat (2) cycle();
        reset = 1'b0;
    endtask

    initial begin
        int a0;
        reset       = 1'b1;
        mem_busy    = 1'b0;
        mem_data    = '0;
        insn_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        salt        = $urandom;

        // Reset values
        repeat (2) cycle();
        check("rst_enable", mem_enable, 0);
        check("rst_addr", mem_address, START);
        check("rst_rw", mem_rw, 0);
        check("rst_size", mem_access_size, 2'b01);
        check("rst_valid", insn_valid, 0);
        check("rst_insn", insn, 0);
        check("rst_pc", insn_pc, 0);

        // First burst after reset release, words 0xA0..0xA3
        use_seq    = 1'b1;
        reset      = 1'b0;
        insn_ready = 1'b1;
        cycle();
        check("t1_first_enable", mem_enable, 1);
        check("t1_first_addr", mem_address, START);
        cycle();
        check("t1_accepts", accepts, 1);
        check("t1_enable_drop", mem_enable, 0);
        cycle();
        check("t1_head_insn", insn, 32'hA0);
        check("t1_head_pc", insn_pc, START);
        wait_for_enable(20, "t1_next_req");
        check("t1_next_addr", mem_address, START + 32'h10);
        cycle();
        check("t1_pops", pops, 4);

        // Fill with decode stalled, then space rule on pops
        apply_reset();
        use_seq    = 1'b0;
        insn_ready = 1'b0;
        a0 = accepts;
        repeat (40) cycle();
        check("t2_bursts", accepts - a0, 4);
        check("t2_no_fifth", mem_enable, 0);
        check("t2_full_valid", insn_valid, 1);
        insn_ready = 1'b1;
        cycle();
        insn_ready = 1'b0;
        repeat (8) cycle();
        check("t2_one_pop_no_req", mem_enable, 0);
        check("t2_one_pop_bursts", accepts - a0, 4);
        insn_ready = 1'b1;
        repeat (3) cycle();
        insn_ready = 1'b0;
        wait_for_enable(4, "t2_req_after_pops");
        check("t2_req_addr", mem_address, START + 32'h40);

        // Redirect on the edge carrying word 1
        apply_reset();
        insn_ready = 1'b0;
        a0 = accepts;
        for (int i = 0; i < 10 && accepts == a0; i++) cycle();
        check("t3_accept", accepts - a0, 1);
        cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h80020103;
        cycle();
        redirect = 1'b0;
        check("t3_flush_valid", insn_valid, 0);
        wait_for_enable(10, "t3_req");
        check("t3_req_addr", mem_address, 32'h80020100);
        insn_ready = 1'b1;
        for (int i = 0; i < 10 && insn_valid !== 1'b1; i++) cycle();
        check("t3_first_pc", insn_pc, 32'h80020100);

        // Memory busy for 5 cycles while a request is pending
        apply_reset();
        insn_ready = 1'b1;
        a0 = accepts;
        cycle();
        stall_left = 5;
        drive_mem();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t4_hold_enable", mem_enable, 1);
            check("t4_hold_addr", mem_address, START);
        end
        check("t4_no_accept", accepts - a0, 0);
        cycle();
        check("t4_accept_6th", accepts - a0, 1);
        check("t4_enable_drop", mem_enable, 0);
        wait_for_enable(10, "t4_next_req");
        check("t4_next_addr", mem_address, START + 32'h10);

        // Address wrap at the top of the space
        apply_reset();
        insn_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFFFFF0;
        cycle();
        redirect = 1'b0;
        check("t5_idle_redirect", mem_enable, 0);
        cycle();
        check("t5_req_enable", mem_enable, 1);
        check("t5_req_addr", mem_address, 32'hFFFFFFF0);
        cycle();
        wait_for_enable(10, "t5_wrap_req");
        check("t5_wrap_addr", mem_address, 32'h0);
        insn_ready = 1'b1;
        repeat (12) cycle();

        // Reset in the middle of a burst
        a0 = accepts;
        for (int i = 0; i < 10 && accepts == a0; i++) cycle();
        check("t6_accept", accepts - a0, 1);
        cycle();
        reset = 1'b1;
        cycle();
        check("t6_enable", mem_enable, 0);
        check("t6_addr", mem_address, START);
        check("t6_valid", insn_valid, 0);
        check("t6_insn", insn, 0);
        check("t6_pc", insn_pc, 0);
        reset = 1'b0;
        cycle();
        check("t6_restart_enable", mem_enable, 1);
        check("t6_restart_addr", mem_address, START);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            insn_ready  = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 31)))
                                                      : $urandom;
            reset       = ($urandom_range(0, 399) == 0);
            if (busy_left == 0 && stall_left == 0 && $urandom_range(0, 7) == 0) begin
                stall_left = $urandom_range(1, 4);
            end
            drive_mem();
            cycle();
        end
        reset      = 1'b0;
        redirect   = 1'b0;
        insn_ready = 1'b1;
        repeat (50) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
